// File: rtl/pfd_tdc.sv
// Phase-frequency detector that measures ref/fb phase error in sys_clk cycles.
// Optional deadzone zeroing is compiled in with `define PFD_TDC_DEADZONE_EN.
module pfd_tdc #(
    parameter int SYNC_STAGES = 2,
    parameter int ERR_W       = 8,
    parameter int LOCK_THRESH = 2,
    parameter int LOCK_COUNT  = 16,
    parameter int DEADZONE    = 1
) (
    input  logic                    sys_clk,
    input  logic                    rst,
    input  logic                    ref_clk,
    input  logic                    fb_clk,
    output logic signed [ERR_W-1:0] error_out,
    output logic                    sample_en,
    output logic                    up,
    output logic                    dn,
    output logic                    slip,
    output logic                    locked
);

    localparam int CNT_W = ERR_W - 1;
    localparam int LC_W  = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] ERR_MAX = '1;
    localparam logic [CNT_W-1:0] DZ_MAG  = CNT_W'(DEADZONE);
    localparam logic [CNT_W-1:0] LT_MAG  = CNT_W'(LOCK_THRESH);
    localparam logic [LC_W-1:0]  LC_MAX  = LC_W'(LOCK_COUNT);
`ifdef PFD_TDC_DEADZONE_EN
    localparam bit DZ_EN = 1'b1;
`else
    localparam bit DZ_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        UP,
        DOWN
    } state_t;

    logic [SYNC_STAGES:0]   ref_sync_q, fb_sync_q;
    logic [SYNC_STAGES-1:0] fill_q;
    logic                   ref_armed_q, fb_armed_q;
    logic                   ref_rise, fb_rise;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [ERR_W-1:0]  err_q, err_d;
    logic              sample_q, slip_q, up_q, dn_q, locked_q;
    logic              sample_d, slip_d, locked_d;
    logic [LC_W-1:0]   lock_cnt_q, lock_cnt_d;

    logic              emit, emit_neg;
    logic [CNT_W-1:0]  emit_mag, out_mag;
    logic [ERR_W-1:0]  pos_val, emit_val;
    logic              in_win;

    // fill_q marks when the last sync stage holds a real post-reset sample, so an
    // input that was already high at reset release must first be seen low (armed).
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            ref_sync_q  <= '0;
            fb_sync_q   <= '0;
            fill_q      <= '0;
            ref_armed_q <= 1'b0;
            fb_armed_q  <= 1'b0;
        end else begin
            ref_sync_q  <= {ref_sync_q[SYNC_STAGES-1:0], ref_clk};
            fb_sync_q   <= {fb_sync_q[SYNC_STAGES-1:0], fb_clk};
            fill_q      <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            ref_armed_q <= ref_armed_q | (fill_q[SYNC_STAGES-1] & ~ref_sync_q[SYNC_STAGES-1]);
            fb_armed_q  <= fb_armed_q | (fill_q[SYNC_STAGES-1] & ~fb_sync_q[SYNC_STAGES-1]);
        end
    end

    assign ref_rise = ref_armed_q & ref_sync_q[SYNC_STAGES-1] & ~ref_sync_q[SYNC_STAGES];
    assign fb_rise  = fb_armed_q & fb_sync_q[SYNC_STAGES-1] & ~fb_sync_q[SYNC_STAGES];
    assign cnt_inc  = (cnt_q == ERR_MAX) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        emit     = 1'b0;
        emit_neg = 1'b0;
        emit_mag = '0;
        slip_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (ref_rise && fb_rise) begin
                    emit = 1'b1;
                end else if (ref_rise) begin
                    state_d = UP;
                    cnt_d   = CNT_W'(1);
                end else if (fb_rise) begin
                    state_d = DOWN;
                    cnt_d   = CNT_W'(1);
                end
            end
            UP: begin
                if (fb_rise) begin
                    emit     = 1'b1;
                    emit_mag = cnt_q;
                    state_d  = IDLE;
                    cnt_d    = '0;
                end else if (ref_rise) begin
                    emit     = 1'b1;
                    emit_mag = ERR_MAX;
                    slip_d   = 1'b1;
                    cnt_d    = CNT_W'(1);
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            DOWN: begin
                emit_neg = 1'b1;
                if (ref_rise) begin
                    emit     = 1'b1;
                    emit_mag = cnt_q;
                    state_d  = IDLE;
                    cnt_d    = '0;
                end else if (fb_rise) begin
                    emit     = 1'b1;
                    emit_mag = ERR_MAX;
                    slip_d   = 1'b1;
                    cnt_d    = CNT_W'(1);
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Slip samples bypass the deadzone; lock is judged on the value actually emitted.
    always_comb begin
        out_mag = (DZ_EN && !slip_d && emit_mag <= DZ_MAG) ? '0 : emit_mag;
        pos_val = {1'b0, out_mag};
        emit_val = emit_neg ? -pos_val : pos_val;
        in_win  = !slip_d && (out_mag <= LT_MAG);
        sample_d   = emit;
        err_d      = err_q;
        lock_cnt_d = lock_cnt_q;
        locked_d   = locked_q;
        if (emit) begin
            err_d = emit_val;
            if (in_win) begin
                lock_cnt_d = (lock_cnt_q == LC_MAX) ? lock_cnt_q : lock_cnt_q + 1'b1;
            end else begin
                lock_cnt_d = '0;
            end
            locked_d = (lock_cnt_d == LC_MAX);
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            err_q      <= '0;
            sample_q   <= 1'b0;
            slip_q     <= 1'b0;
            up_q       <= 1'b0;
            dn_q       <= 1'b0;
            lock_cnt_q <= '0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            sample_q   <= sample_d;
            slip_q     <= slip_d;
            up_q       <= (state_d == UP);
            dn_q       <= (state_d == DOWN);
            lock_cnt_q <= lock_cnt_d;
            locked_q   <= locked_d;
        end
    end

    assign error_out = err_q;
    assign sample_en = sample_q;
    assign up        = up_q;
    assign dn        = dn_q;
    assign slip      = slip_q;
    assign locked    = locked_q;

endmodule

// File: doc/pfd_tdc.md
# pfd_tdc

Parametrised phase-frequency detector with time-to-digital measurement. It sits between the reference/feedback clock inputs and the digital loop filter of the Tiny-PLL. Instead of a continuous ±1 level, it measures the phase error as a signed count of sys_clk cycles and delivers one sample per reference/feedback edge pair. It also provides UP/DN levels, cycle-slip detection and a lock indicator.

## Interface
- SYNC_STAGES, 2: synchronizer flops per input, ≥2; edge detect uses one extra flop after the chain.
- ERR_W, 8: signed width of error_out; ERR_MAX = 2^(ERR_W-1)-1.
- LOCK_THRESH, 2: |error| ≤ LOCK_THRESH counts as in-window.
- LOCK_COUNT, 16: consecutive in-window samples required to assert locked, ≥1.
- DEADZONE, 1: magnitude forced to zero when the deadzone feature is compiled in.
- sys_clk  in  1  system clock (100 MHz); only clock.
- rst  in  1  asynchronous, active-high reset.
- ref_clk  in  1  asynchronous reference clock.
- fb_clk  in  1  asynchronous feedback clock.
- error_out  out  ERR_W  signed phase error in sys_clk cycles; positive means ref leads.
- sample_en  out  1  one-cycle strobe; error_out is new and valid.
- up  out  1  high while in UP state.
- dn  out  1  high while in DOWN state.
- slip  out  1  one-cycle strobe on a detected cycle slip.
- locked  out  1  lock indicator.

## Operation
- Each input passes through SYNC_STAGES flops plus one delay flop. A rise is detected when the last two flops read 01.
- States are IDLE, UP and DOWN. A counter cnt saturates at ERR_MAX.
- IDLE:
  - ref_rise only: go to UP, cnt←1.
  - fb_rise only: go to DOWN, cnt←1.
  - Both edges in the same cycle: emit a 0 sample and stay in IDLE.
- UP:
  - Each cycle without fb_rise: cnt←min(cnt+1, ERR_MAX).
  - fb_rise: emit +cnt and go to IDLE. A concurrent ref_rise in that cycle is dropped.
  - ref_rise without fb_rise (cycle slip): emit +ERR_MAX, pulse slip, cnt←1, stay in UP.
- DOWN: mirror of UP with the inputs swapped. Samples are −cnt, and a slip emits −ERR_MAX.
- Emitting a sample means error_out←value and sample_en←1 for one cycle.
- error_out holds its last value between samples.
- up = (state==UP) and dn = (state==DOWN), both registered.
- Lock logic is evaluated on every emitted sample:
  - In-window sample (|value| ≤ LOCK_THRESH, slip=0): lock_cnt increments, saturating at LOCK_COUNT. locked←1 when lock_cnt reaches LOCK_COUNT.
  - Any other sample, including a slip: lock_cnt←0 and locked←0.
  - locked updates in the same cycle as sample_en.
- Arithmetic: cnt is unsigned ERR_W-1 bits. Negation −ERR_MAX is always representable, so −2^(ERR_W-1) is never produced.

## Timing
- Input edge to detected rise: SYNC_STAGES+1 sys_clk cycles.
- Detected closing edge to sample_en/error_out: 1 cycle, registered.
- Closing edge detected k cycles after the opening edge gives magnitude k, saturated at ERR_MAX.
- up/dn assert 1 cycle after the opening rise is detected and deassert 1 cycle after the closing rise.
- Reset (async assert; release synchronous to sys_clk):
  - Outputs: error_out=0, sample_en=0, up=0, dn=0, slip=0, locked=0.
  - Internal: state=IDLE, cnt=0, lock_cnt=0, synchronizers=0.
- Reset mid-measurement aborts the measurement and emits no sample.
- An input already high at reset release does not produce a rise until a 0 has been sampled.

## Configuration
- PFD_TDC_DEADZONE_EN defined:
  - Samples with |value| ≤ DEADZONE are emitted as 0, with sample_en still pulsed.
  - Lock evaluation uses the post-deadzone value.
  - Slip samples are never zeroed.
- Not defined: DEADZONE is ignored and samples are exact.

## Test plan
- Reset: assert rst mid-UP with ref_clk high → all outputs 0 immediately. After release, sample_en stays 0 until fresh edges arrive.
- Ref leads fb by 5 detected cycles (ERR_W=8) → error_out=+5 with a 1-cycle sample_en; up high for 5 cycles; dn=0.
- Fb leads by 300 cycles (ERR_W=8) → error_out=−127 (saturated); slip=0.
- Two ref rises with no fb in between → slip pulse, error_out=+127, state still UP; a following fb 3 cycles later → error_out=+3.
- Simultaneous ref/fb rises repeated LOCK_COUNT=16 times → 16 samples of 0; locked rises with the 16th sample_en; next sample of +4 (LOCK_THRESH=2) → locked=0.
- With PFD_TDC_DEADZONE_EN, DEADZONE=1: lead of 1 cycle → error_out=0; lead of 2 cycles → +2. Without the macro, a 1-cycle lead → +1.
